// File: rtl/osd_u8g2_tx_if.sv
// Host-side port bundle of the OSD byte-stream transmitter: shadow writes,
// show/hide requests, busy status and the strobed output byte stream.
interface osd_u8g2_tx_if;
    logic       wr_en;
    logic [9:0] wr_addr;
    logic [7:0] wr_data;
    logic       show_req;
    logic       show_val;
    logic       busy;
    logic       data_out_strobe;
    logic       data_out_start;
    logic [7:0] data_out;

    modport master (
        output wr_en, wr_addr, wr_data, show_req, show_val,
        input  busy, data_out_strobe, data_out_start, data_out
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, show_req, show_val,
        output busy, data_out_strobe, data_out_start, data_out
    );
endinterface

// File: rtl/osd_u8g2_tx.sv
// OSD transmitter: 1024-byte display shadow with per-tile dirty tracking, emits
// show/hide and tile-update command sequences. Optional macro OSD_U8G2_TX_BURST_EN.
module osd_u8g2_tx #(
    parameter int STROBE_GAP = 0
) (
    input  logic          clk,
    input  logic          reset,
    osd_u8g2_tx_if.slave  bus
);
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_CMD_HDR,
        ST_CMD_ADDR,
        ST_DATA,
        ST_EN_HDR,
        ST_EN_VAL
    } state_t;

    localparam logic [3:0] GAP_W = 4'(STROBE_GAP);

    logic [7:0]   shadow_mem_r [0:1023];
    logic [7:0]   rd_q_r;
    state_t       state_r;
    logic [127:0] dirty_r;
    logic [127:0] dirty_nxt_s;
    logic         show_pend_r;
    logic         show_val_r;
    logic         en_val_r;
    logic [6:0]   scan_r;
    logic [6:0]   tile_r;
    logic [2:0]   byte_idx_r;
    logic         burst_r;
    logic [3:0]   gap_cnt_r;
    logic         strobe_r;
    logic         start_r;
    logic [7:0]   data_r;

    logic         can_emit_s;
    logic         emit_data_s;
    logic         take_show_s;
    logic         clr_s;
    logic         any_dirty_s;
    logic [9:0]   rd_addr_s;

    assign can_emit_s  = (gap_cnt_r == 4'd0);
    assign emit_data_s = can_emit_s && ((state_r == ST_CMD_ADDR) || (state_r == ST_DATA));
    assign take_show_s = can_emit_s && show_pend_r && ((state_r == ST_IDLE) || (state_r == ST_SCAN));
    // A tile's dirty bit drops on its address byte, or on its first byte when burst-continued.
    assign clr_s       = can_emit_s && ((state_r == ST_CMD_HDR) ||
                         ((state_r == ST_DATA) && burst_r && (byte_idx_r == 3'd0)));
    assign any_dirty_s = |dirty_r;
    // Read one byte ahead whenever a data byte leaves, so rd_q always holds the next byte.
    assign rd_addr_s   = {tile_r, byte_idx_r} + (emit_data_s ? 10'd1 : 10'd0);

    assign bus.busy            = (state_r != ST_IDLE) | show_pend_r | any_dirty_s;
    assign bus.data_out_strobe = strobe_r;
    assign bus.data_out_start  = start_r;
    assign bus.data_out        = data_r;

    // Next dirty vector: clear of the tile in flight, then a same-cycle host write wins.
    always_comb begin
        dirty_nxt_s = dirty_r;
        dirty_nxt_s[tile_r] = dirty_r[tile_r] & ~clr_s;
        dirty_nxt_s[bus.wr_addr[9:3]] = dirty_nxt_s[bus.wr_addr[9:3]] | bus.wr_en;
    end

    // Shadow RAM: host write port and one-cycle-latency stream read port.
    always_ff @(posedge clk) begin
        if (bus.wr_en) begin
            shadow_mem_r[bus.wr_addr] <= bus.wr_data;
        end
        rd_q_r <= shadow_mem_r[rd_addr_s];
    end

    // Dirty bits and the pending show/hide request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dirty_r     <= 128'd0;
            show_pend_r <= 1'b0;
            show_val_r  <= 1'b0;
        end else begin
            dirty_r <= dirty_nxt_s;
            if (bus.show_req) begin
                show_pend_r <= 1'b1;
                show_val_r  <= bus.show_val;
            end else if (take_show_s) begin
                show_pend_r <= 1'b0;
            end
        end
    end

    // Sequencer: the state names the byte currently presented on the output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            scan_r     <= 7'd0;
            tile_r     <= 7'd0;
            byte_idx_r <= 3'd0;
            burst_r    <= 1'b0;
            en_val_r   <= 1'b0;
            gap_cnt_r  <= 4'd0;
            strobe_r   <= 1'b0;
            start_r    <= 1'b0;
            data_r     <= 8'h00;
        end else begin
            strobe_r <= 1'b0;
            start_r  <= 1'b0;
            data_r   <= 8'h00;
            if (gap_cnt_r != 4'd0) begin
                gap_cnt_r <= gap_cnt_r - 4'd1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (show_pend_r) begin
                        if (can_emit_s) begin
                            strobe_r  <= 1'b1;
                            start_r   <= 1'b1;
                            data_r    <= 8'h01;
                            gap_cnt_r <= GAP_W;
                            en_val_r  <= show_val_r;
                            state_r   <= ST_EN_HDR;
                        end
                    end else if (any_dirty_s) begin
                        state_r <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (show_pend_r) begin
                        if (can_emit_s) begin
                            strobe_r  <= 1'b1;
                            start_r   <= 1'b1;
                            data_r    <= 8'h01;
                            gap_cnt_r <= GAP_W;
                            en_val_r  <= show_val_r;
                            state_r   <= ST_EN_HDR;
                        end
                    end else if (dirty_r[scan_r]) begin
                        if (can_emit_s) begin
                            strobe_r   <= 1'b1;
                            start_r    <= 1'b1;
                            data_r     <= 8'h02;
                            gap_cnt_r  <= GAP_W;
                            tile_r     <= scan_r;
                            byte_idx_r <= 3'd0;
                            burst_r    <= 1'b0;
                            state_r    <= ST_CMD_HDR;
                        end
                    end else if (!any_dirty_s) begin
                        state_r <= ST_IDLE;
                    end else begin
                        scan_r <= scan_r + 7'd1;
                    end
                end
                ST_CMD_HDR: begin
                    if (can_emit_s) begin
                        strobe_r  <= 1'b1;
                        data_r    <= {1'b0, tile_r};
                        gap_cnt_r <= GAP_W;
                        state_r   <= ST_CMD_ADDR;
                    end
                end
                ST_CMD_ADDR: begin
                    if (can_emit_s) begin
                        strobe_r   <= 1'b1;
                        data_r     <= rd_q_r;
                        gap_cnt_r  <= GAP_W;
                        byte_idx_r <= 3'd1;
                        state_r    <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (can_emit_s) begin
                        strobe_r  <= 1'b1;
                        data_r    <= rd_q_r;
                        gap_cnt_r <= GAP_W;
                        burst_r   <= 1'b0;
                        if (byte_idx_r != 3'd7) begin
                            byte_idx_r <= byte_idx_r + 3'd1;
                        end else begin
`ifdef OSD_U8G2_TX_BURST_EN
                            // Receiver auto-increments its address, so the next tile needs no header.
                            if ((tile_r != 7'd127) && dirty_r[tile_r + 7'd1] && !show_pend_r) begin
                                tile_r     <= tile_r + 7'd1;
                                byte_idx_r <= 3'd0;
                                burst_r    <= 1'b1;
                            end else begin
                                scan_r     <= tile_r + 7'd1;
                                byte_idx_r <= 3'd0;
                                state_r    <= ST_IDLE;
                            end
`else
                            scan_r     <= tile_r + 7'd1;
                            byte_idx_r <= 3'd0;
                            state_r    <= ST_IDLE;
`endif
                        end
                    end
                end
                ST_EN_HDR: begin
                    if (can_emit_s) begin
                        strobe_r  <= 1'b1;
                        data_r    <= {7'd0, en_val_r};
                        gap_cnt_r <= GAP_W;
                        state_r   <= ST_EN_VAL;
                    end
                end
                ST_EN_VAL: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_osd_u8g2_tx.sv
// Directed bench for osd_u8g2_tx: one instance with no strobe gap, one with a
// gap of 3; captured strobes are compared against hand-built byte lists.
module tb_osd_u8g2_tx;
    typedef struct packed {
        logic        start;
        logic [7:0]  data;
        logic [31:0] cyc;
    } seen_t;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   req_cyc = 0;

    logic       wr_en_d   [2];
    logic [9:0] wr_addr_d [2];
    logic [7:0] wr_data_d [2];
    logic       show_req_d[2];
    logic       show_val_d[2];

    seen_t      qa[$];
    seen_t      qb[$];
    logic [8:0] exp_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    osd_u8g2_tx_if bus_a ();
    osd_u8g2_tx_if bus_b ();

    assign bus_a.wr_en    = wr_en_d[0];
    assign bus_a.wr_addr  = wr_addr_d[0];
    assign bus_a.wr_data  = wr_data_d[0];
    assign bus_a.show_req = show_req_d[0];
    assign bus_a.show_val = show_val_d[0];
    assign bus_b.wr_en    = wr_en_d[1];
    assign bus_b.wr_addr  = wr_addr_d[1];
    assign bus_b.wr_data  = wr_data_d[1];
    assign bus_b.show_req = show_req_d[1];
    assign bus_b.show_val = show_val_d[1];

    osd_u8g2_tx #(.STROBE_GAP(0)) dut_a (.clk(clk), .reset(rst_a), .bus(bus_a));
    osd_u8g2_tx #(.STROBE_GAP(3)) dut_b (.clk(clk), .reset(rst_b), .bus(bus_b));

    always @(negedge clk) begin
        seen_t e;
        if (bus_a.data_out_strobe) begin
            e.start = bus_a.data_out_start;
            e.data  = bus_a.data_out;
            e.cyc   = 32'(cyc);
            qa.push_back(e);
        end
        if (bus_b.data_out_strobe) begin
            e.start = bus_b.data_out_start;
            e.data  = bus_b.data_out;
            e.cyc   = 32'(cyc);
            qb.push_back(e);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic write_tile(input int which, input int tile, input logic [7:0] base);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            wr_en_d[which]   = 1'b1;
            wr_addr_d[which] = 10'(tile * 8 + k);
            wr_data_d[which] = base + 8'(k);
        end
        @(negedge clk);
        wr_en_d[which] = 1'b0;
    endtask

    task automatic pulse_show(input int which, input logic val);
        @(negedge clk);
        show_req_d[which] = 1'b1;
        show_val_d[which] = val;
        @(negedge clk);
        show_req_d[which] = 1'b0;
        req_cyc = cyc;
    endtask

    task automatic expect_tile(input logic [6:0] tile, input logic [7:0] base);
        exp_q.push_back({1'b1, 8'h02});
        exp_q.push_back({1'b0, 1'b0, tile});
        for (int k = 0; k < 8; k++) exp_q.push_back({1'b0, base + 8'(k)});
    endtask

    task automatic wait_count(input int which, input int n, input int budget);
        int k = 0;
        while (((which == 0) ? qa.size() : qb.size()) < n && k < budget) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic check_seq(input int which, input string tag, input int step);
        seen_t q[$];
        q = (which == 0) ? qa : qb;
        check_eq({tag, " count"}, 32'(q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < q.size(); i++) begin
            check_eq($sformatf("%s byte%0d", tag, i), {23'd0, q[i].start, q[i].data}, {23'd0, exp_q[i]});
            if (step != 0 && i > 0)
                check_eq($sformatf("%s spacing%0d", tag, i), q[i].cyc - q[i-1].cyc, 32'(step));
        end
    endtask

    initial begin
        bit found;
        for (int i = 0; i < 2; i++) begin
            wr_en_d[i] = 1'b0; wr_addr_d[i] = 10'd0; wr_data_d[i] = 8'd0;
            show_req_d[i] = 1'b0; show_val_d[i] = 1'b0;
        end
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("reset a outs", {29'd0, bus_a.busy, bus_a.data_out_strobe, bus_a.data_out_start}, 32'd0);
        check_eq("reset a data", {24'd0, bus_a.data_out}, 32'd0);
        check_eq("reset b outs", {29'd0, bus_b.busy, bus_b.data_out_strobe, bus_b.data_out_start}, 32'd0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(negedge clk);
        check_eq("idle busy a", {31'd0, bus_a.busy}, 32'd0);

        // show command, no gap
        qa.delete(); exp_q.delete();
        pulse_show(0, 1'b1);
        wait_count(0, 2, 20);
        repeat (3) @(negedge clk);
        exp_q.push_back({1'b1, 8'h01});
        exp_q.push_back({1'b0, 8'h01});
        check_seq(0, "show_on", 1);
        check_eq("show_on latency", (qa.size() > 0) ? qa[0].cyc - 32'(req_cyc) : 32'hFFFF_FFFF, 32'd1);
        check_eq("show_on busy", {31'd0, bus_a.busy}, 32'd0);

        // gap of 3: show command then tile 10
        qb.delete(); exp_q.delete();
        pulse_show(1, 1'b0);
        wait_count(1, 2, 40);
        repeat (6) @(negedge clk);
        exp_q.push_back({1'b1, 8'h01});
        exp_q.push_back({1'b0, 8'h00});
        check_seq(1, "gap_show", 4);
        qb.delete(); exp_q.delete();
        write_tile(1, 10, 8'h50);
        wait_count(1, 10, 200);
        repeat (10) @(negedge clk);
        expect_tile(7'd10, 8'h50);
        check_seq(1, "gap_tile", 4);
        check_eq("gap_tile busy", {31'd0, bus_b.busy}, 32'd0);

        // single tile 5 from addresses 40..47
        qa.delete(); exp_q.delete();
        write_tile(0, 5, 8'h10);
        wait_count(0, 10, 100);
        repeat (5) @(negedge clk);
        expect_tile(7'd5, 8'h10);
        check_seq(0, "tile5", 1);
        check_eq("tile5 busy", {31'd0, bus_a.busy}, 32'd0);

        // tiles 5 and 6 dirty together
        qa.delete(); exp_q.delete();
        write_tile(0, 5, 8'hA0);
        write_tile(0, 6, 8'hB0);
`ifdef OSD_U8G2_TX_BURST_EN
        expect_tile(7'd5, 8'hA0);
        for (int k = 0; k < 8; k++) exp_q.push_back({1'b0, 8'hB0 + 8'(k)});
`else
        expect_tile(7'd5, 8'hA0);
        expect_tile(7'd6, 8'hB0);
`endif
        wait_count(0, exp_q.size(), 400);
        repeat (20) @(negedge clk);
        check_seq(0, "tiles56", 0);
        check_eq("tiles56 busy", {31'd0, bus_a.busy}, 32'd0);

        // show request and tile-5 rewrite while tile 5 is in flight
        qa.delete(); exp_q.delete();
        write_tile(0, 5, 8'hC0);
        write_tile(0, 9, 8'h90);
        found = 1'b0;
        for (int k = 0; k < 400 && !found; k++) begin
            @(negedge clk);
            if (bus_a.data_out_strobe && !bus_a.data_out_start && bus_a.data_out == 8'h05) found = 1'b1;
        end
        check_eq("mid trigger", {31'd0, found}, 32'd1);
        show_req_d[0] = 1'b1; show_val_d[0] = 1'b0;
        wr_en_d[0] = 1'b1; wr_addr_d[0] = 10'd40; wr_data_d[0] = 8'hD0;
        @(negedge clk);
        show_req_d[0] = 1'b0;
        wr_en_d[0] = 1'b0;
        expect_tile(7'd5, 8'hC0);
        exp_q.push_back({1'b1, 8'h01});
        exp_q.push_back({1'b0, 8'h00});
        expect_tile(7'd9, 8'h90);
        expect_tile(7'd5, 8'hC0);
        exp_q[24] = {1'b0, 8'hD0};
        wait_count(0, 32, 600);
        repeat (20) @(negedge clk);
        check_seq(0, "show_mid", 0);
        check_eq("show_mid busy", {31'd0, bus_a.busy}, 32'd0);

        // reset in the middle of a tile sequence
        qa.delete();
        write_tile(0, 6, 8'hE0);
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(negedge clk);
            if (qa.size() >= 3 && bus_a.data_out_strobe) found = 1'b1;
        end
        check_eq("rst trigger", {31'd0, found}, 32'd1);
        rst_a = 1'b1;
        #1;
        check_eq("rst outs", {29'd0, bus_a.busy, bus_a.data_out_strobe, bus_a.data_out_start}, 32'd0);
        check_eq("rst data", {24'd0, bus_a.data_out}, 32'd0);
        qa.delete();
        repeat (2) @(negedge clk);
        rst_a = 1'b0;
        repeat (40) @(negedge clk);
        check_eq("rst no strobes", 32'(qa.size()), 32'd0);
        check_eq("rst busy", {31'd0, bus_a.busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
